// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: captures decode/regfile outputs for EX, with stall hold, flush bubbles and a bubble counter.
// Latency: 1 cycle id_* -> ex_*, all outputs registered. Backpressure: stall holds contents, flush overrides stall.
// Optional IDEX_WB_BYPASS_EN forwards a same-cycle WB write into ex_read_data1/2.
module id_ex_pipeline_reg #(
   parameter int DATA_W     = 64,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  id_valid,
   input  logic [DATA_W-1:0]     id_pc,
   input  logic [DATA_W-1:0]     id_read_data1,
   input  logic [DATA_W-1:0]     id_read_data2,
   input  logic [DATA_W-1:0]     id_imm,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic [3:0]            id_funct4,
   input  logic [7:0]            id_ctrl,
   input  logic                  wb_reg_write,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic [DATA_W-1:0]     wb_write_data,
   output logic                  ex_valid,
   output logic [DATA_W-1:0]     ex_pc,
   output logic [DATA_W-1:0]     ex_read_data1,
   output logic [DATA_W-1:0]     ex_read_data2,
   output logic [DATA_W-1:0]     ex_imm,
   output logic [REG_ADDR_W-1:0] ex_rs1,
   output logic [REG_ADDR_W-1:0] ex_rs2,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic [3:0]            ex_funct4,
   output logic [7:0]            ex_ctrl,
   output logic [CNT_W-1:0]      bubble_count
);

   logic [DATA_W-1:0] rd1_next;
   logic [DATA_W-1:0] rd2_next;

`ifdef IDEX_WB_BYPASS_EN
   always_comb begin
      rd1_next = id_read_data1;
      rd2_next = id_read_data2;
      // x0 is never forwarded: a write to it is architecturally discarded
      if (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs1))
         rd1_next = wb_write_data;
      if (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs2))
         rd2_next = wb_write_data;
   end
`else
   logic unused_wb;
   assign unused_wb = ^{wb_reg_write, wb_rd, wb_write_data};

   always_comb begin
      rd1_next = id_read_data1;
      rd2_next = id_read_data2;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid      <= 1'b0;
         ex_pc         <= '0;
         ex_read_data1 <= '0;
         ex_read_data2 <= '0;
         ex_imm        <= '0;
         ex_rs1        <= '0;
         ex_rs2        <= '0;
         ex_rd         <= '0;
         ex_funct4     <= '0;
         ex_ctrl       <= '0;
         bubble_count  <= '0;
      end else if (flush) begin
         ex_valid      <= 1'b0;
         ex_pc         <= '0;
         ex_read_data1 <= '0;
         ex_read_data2 <= '0;
         ex_imm        <= '0;
         ex_rs1        <= '0;
         ex_rs2        <= '0;
         ex_rd         <= '0;
         ex_funct4     <= '0;
         ex_ctrl       <= '0;
         if (bubble_count != '1)
            bubble_count <= bubble_count + CNT_W'(1);
      end else if (!stall) begin
         ex_valid      <= id_valid;
         ex_pc         <= id_pc;
         ex_read_data1 <= rd1_next;
         ex_read_data2 <= rd2_next;
         ex_imm        <= id_imm;
         ex_rs1        <= id_rs1;
         ex_rs2        <= id_rs2;
         ex_rd         <= id_rd;
         ex_funct4     <= id_funct4;
         // an invalid slot must never carry RegWrite/MemWrite into EX
         ex_ctrl       <= id_valid ? id_ctrl : 8'h00;
      end
   end

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Scoreboard bench for id_ex_pipeline_reg: stimulus queues hand-computed expectations, monitor compares at negedge.
module tb_id_ex_pipeline_reg;

   logic        clk = 1'b0;
   logic        reset, stall, flush, id_valid;
   logic [63:0] id_pc, id_read_data1, id_read_data2, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [3:0]  id_funct4;
   logic [7:0]  id_ctrl;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [63:0] wb_write_data;
   logic        ex_valid;
   logic [63:0] ex_pc, ex_read_data1, ex_read_data2, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [3:0]  ex_funct4;
   logic [7:0]  ex_ctrl;
   logic [15:0] bubble_count;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        valid;
      logic [63:0] pc, rd1, rd2, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [3:0]  f4;
      logic [7:0]  ctrl;
      logic [15:0] bc;
   } obs_t;

   obs_t  exp_q[$];
   string name_q[$];

   id_ex_pipeline_reg dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
      .id_pc(id_pc), .id_read_data1(id_read_data1), .id_read_data2(id_read_data2),
      .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_funct4(id_funct4), .id_ctrl(id_ctrl), .wb_reg_write(wb_reg_write),
      .wb_rd(wb_rd), .wb_write_data(wb_write_data), .ex_valid(ex_valid),
      .ex_pc(ex_pc), .ex_read_data1(ex_read_data1), .ex_read_data2(ex_read_data2),
      .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_funct4(ex_funct4), .ex_ctrl(ex_ctrl), .bubble_count(bubble_count)
   );

   always #5 clk = ~clk;

   function automatic obs_t mk(input logic v, input logic [63:0] pc, r1, r2, imm,
                               input logic [4:0] rs1, rs2, rd, input logic [3:0] f4,
                               input logic [7:0] ctrl, input logic [15:0] bc);
      obs_t o;
      o.valid = v; o.pc = pc; o.rd1 = r1; o.rd2 = r2; o.imm = imm;
      o.rs1 = rs1; o.rs2 = rs2; o.rd = rd; o.f4 = f4; o.ctrl = ctrl; o.bc = bc;
      return o;
   endfunction

   task automatic set_id(input logic v, input logic [63:0] pc, r1, r2, imm,
                         input logic [4:0] rs1, rs2, rd, input logic [3:0] f4,
                         input logic [7:0] ctrl);
      id_valid = v; id_pc = pc; id_read_data1 = r1; id_read_data2 = r2; id_imm = imm;
      id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_funct4 = f4; id_ctrl = ctrl;
   endtask

   // one clock edge; the expectation describes the outputs after this edge
   task automatic cyc(input obs_t e, input string nm, input bit chk);
      @(posedge clk);
      #1;
      if (chk) begin
         exp_q.push_back(e);
         name_q.push_back(nm);
      end
   endtask

   // monitor
   initial begin
      obs_t  act, exp;
      string nm;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = mk(ex_valid, ex_pc, ex_read_data1, ex_read_data2, ex_imm,
                     ex_rs1, ex_rs2, ex_rd, ex_funct4, ex_ctrl, bubble_count);
            checks++;
            if (act !== exp) begin
               errors++;
               $display("FAIL %s got=%h want=%h", nm, act, exp);
            end
         end
      end
   end

   obs_t zero0;
   logic [63:0] bp_exp;

   initial begin
      zero0 = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef IDEX_WB_BYPASS_EN
      bp_exp = 64'hDEAD;
`else
      bp_exp = 64'h1;
`endif
      // reset with every input nonzero, flush also asserted
      reset = 1; stall = 0; flush = 1;
      wb_reg_write = 1; wb_rd = 5'd3; wb_write_data = 64'h77;
      set_id(1, 64'h111, 64'h222, 64'h333, 64'h444, 5'd3, 5'd3, 5'd5, 4'hA, 8'hFF);
      cyc(zero0, "reset1", 1);
      cyc(zero0, "reset2", 1);

      reset = 0; flush = 0; wb_reg_write = 0; wb_rd = 0; wb_write_data = 0;
      set_id(1, 64'h40, 64'h1234, 64'h5678, 64'h10, 5'd1, 5'd2, 5'd3, 4'h5, 8'h22);
      cyc(mk(1, 64'h40, 64'h1234, 64'h5678, 64'h10, 1, 2, 3, 4'h5, 8'h22, 0), "first_load", 1);

      set_id(1, 64'h44, 64'hA, 64'hB, 64'hC, 5'd4, 5'd6, 5'd7, 4'h1, 8'h06);
      cyc(mk(1, 64'h44, 64'hA, 64'hB, 64'hC, 4, 6, 7, 4'h1, 8'h06, 0), "load_rd7", 1);

      stall = 1;
      set_id(1, 64'h48, 64'hD, 64'hE, 64'hF, 5'd9, 5'd10, 5'd11, 4'h3, 8'h30);
      for (int i = 0; i < 3; i++) begin
         cyc(mk(1, 64'h44, 64'hA, 64'hB, 64'hC, 4, 6, 7, 4'h1, 8'h06, 0), "stall_hold", 1);
         id_pc = id_pc + 64'h4;
      end
      stall = 0; id_pc = 64'h48;
      cyc(mk(1, 64'h48, 64'hD, 64'hE, 64'hF, 9, 10, 11, 4'h3, 8'h30, 0), "stall_release", 1);

      stall = 1; flush = 1;
      set_id(1, 64'h70, 64'h1, 64'h2, 64'h99, 5'd1, 5'd2, 5'd3, 4'hF, 8'hFF);
      cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'd1), "stall_flush", 1);
      stall = 0;
      cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'd2), "flush2", 1);
      cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'd3), "flush3", 1);
      cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'd4), "flush4", 1);

      flush = 0;
      set_id(0, 64'h50, 64'h3, 64'h4, 64'h5, 5'd7, 5'd8, 5'd9, 4'h2, 8'h24);
      cyc(mk(0, 64'h50, 64'h3, 64'h4, 64'h5, 7, 8, 9, 4'h2, 8'h00, 16'd4), "invalid_slot", 1);

      wb_reg_write = 1; wb_rd = 5'd5; wb_write_data = 64'hDEAD;
      set_id(1, 64'h60, 64'h1, 64'h1, 64'h0, 5'd5, 5'd5, 5'd10, 4'h0, 8'h04);
      cyc(mk(1, 64'h60, bp_exp, bp_exp, 0, 5, 5, 10, 4'h0, 8'h04, 16'd4), "bypass_rs5", 1);

      wb_rd = 5'd0; id_rs1 = 5'd0;
      cyc(mk(1, 64'h60, 64'h1, 64'h1, 0, 0, 5, 10, 4'h0, 8'h04, 16'd4), "bypass_x0", 1);

      // bypass must not act while stalled
      stall = 1; wb_rd = 5'd5; id_rs1 = 5'd5; id_pc = 64'h64;
      cyc(mk(1, 64'h60, 64'h1, 64'h1, 0, 0, 5, 10, 4'h0, 8'h04, 16'd4), "bypass_stalled", 1);

      wb_reg_write = 0; wb_rd = 0; wb_write_data = 0;
      reset = 1;
      cyc(zero0, "reset_mid_stall", 1);

      reset = 0; stall = 0; flush = 1;
      for (int i = 0; i < 65533; i++) cyc(zero0, "", 0);
      cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFFFE), "sat_fffe", 1);
      cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFFFF), "sat_ffff", 1);
      cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFFFF), "sat_hold1", 1);
      cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFFFF), "sat_hold2", 1);

      reset = 1;
      cyc(zero0, "reset_mid_flush", 1);
      reset = 0; flush = 0;
      set_id(1, 64'h80, 64'h5, 64'h6, 64'h7, 5'd1, 5'd2, 5'd3, 4'h4, 8'h81);
      cyc(mk(1, 64'h80, 64'h5, 64'h6, 64'h7, 1, 2, 3, 4'h4, 8'h81, 0), "load_after_reset", 1);

      @(negedge clk);
      @(posedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d want=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
